// File: rtl/astro_game_engine.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : astro_game_engine                                          |
// | Description : Tick-driven shooting-gallery game core. A ship at the      |
// |               bottom fires one bullet at a time upward at NUM_TARGETS    |
// |               targets that bounce horizontally in fixed lanes            |
// |               (lane i at Y = 100 + 50*i). Tracks score, ammo and level.  |
// | Option      : define LEVEL_SPEEDUP_EN to scale the target step with the  |
// |               level (TGT_STEP << min(level,2)); otherwise it stays       |
// |               constant at TGT_STEP.                                      |
// | Ports       : clk, reset (async, active high), tick (update enable),     |
// |               start/btn_left/btn_right/btn_fire (level inputs);          |
// |               ship_x, bullet_active/x/y, tgt_x (packed, 10 bits per      |
// |               target), tgt_hit, score, ammo, level, state.               |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module astro_game_engine #(
  parameter int NUM_TARGETS = 4,
  parameter int AMMO_INIT   = 8,
  parameter int TGT_STEP    = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      tick,
  input  logic                      start,
  input  logic                      btn_left,
  input  logic                      btn_right,
  input  logic                      btn_fire,
  output logic [9:0]                ship_x,
  output logic                      bullet_active,
  output logic [9:0]                bullet_x,
  output logic [9:0]                bullet_y,
  output logic [10*NUM_TARGETS-1:0] tgt_x,
  output logic [NUM_TARGETS-1:0]    tgt_hit,
  output logic [7:0]                score,
  output logic [3:0]                ammo,
  output logic [3:0]                level,
  output logic [1:0]                state
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'b00,
    S_PLAY    = 2'b01,
    S_LVL_CLR = 2'b10,
    S_OVER    = 2'b11
  } state_t;

  // Start positions: (20 + 150*i) mod 600.
  function automatic logic [10*NUM_TARGETS-1:0] reload_x_f();
    logic [10*NUM_TARGETS-1:0] r;
    r = '0;
    for (int i = 0; i < NUM_TARGETS; i++) r[10*i +: 10] = 10'((20 + 150*i) % 600);
    return r;
  endfunction

  // Direction bit: 1 = moving left. Odd targets start moving left.
  function automatic logic [NUM_TARGETS-1:0] reload_dir_f();
    logic [NUM_TARGETS-1:0] r;
    r = '0;
    for (int i = 0; i < NUM_TARGETS; i++) r[i] = 1'(i % 2);
    return r;
  endfunction

  localparam logic [10*NUM_TARGETS-1:0] RELOAD_X   = reload_x_f();
  localparam logic [NUM_TARGETS-1:0]    RELOAD_DIR = reload_dir_f();
  localparam logic [9:0]                SHIP_HOME  = 10'd400;
  localparam logic [3:0]                AMMO_FULL  = 4'(AMMO_INIT);

  state_t                    state_q, state_d;
  logic [9:0]                ship_x_q, ship_x_d;
  logic                      bullet_active_q, bullet_active_d;
  logic [9:0]                bullet_x_q, bullet_x_d;
  logic [9:0]                bullet_y_q, bullet_y_d;
  logic [10*NUM_TARGETS-1:0] tgt_x_q, tgt_x_d;
  logic [NUM_TARGETS-1:0]    tgt_dir_q, tgt_dir_d;
  logic [NUM_TARGETS-1:0]    tgt_hit_q, tgt_hit_d;
  logic [7:0]                score_q, score_d;
  logic [3:0]                ammo_q, ammo_d;
  logic [3:0]                level_q, level_d;

  logic                      all_hit;
  logic                      fire_ok;
  logic                      hit_found;
  logic [9:0]                step_w;
  logic [NUM_TARGETS-1:0]    in_window;

  assign all_hit = &tgt_hit_q;
  assign fire_ok = btn_fire && !btn_left && !btn_right && !bullet_active_q && (ammo_q != 4'd0);

  always_comb begin
`ifdef LEVEL_SPEEDUP_EN
    if (level_q == 4'd0)      step_w = 10'(TGT_STEP);
    else if (level_q == 4'd1) step_w = 10'(TGT_STEP * 2);
    else                      step_w = 10'(TGT_STEP * 4);
`else
    step_w = 10'(TGT_STEP);
`endif
  end

  // Overlap test on the pre-update positions, widened to 11 bits so the +10
  // margins cannot wrap.
  always_comb begin
    in_window = '0;
    for (int i = 0; i < NUM_TARGETS; i++) begin
      in_window[i] = (({1'b0, bullet_x_q} + 11'd10) >= {1'b0, tgt_x_q[10*i +: 10]}) &&
                     ({1'b0, bullet_x_q} <= ({1'b0, tgt_x_q[10*i +: 10]} + 11'd10)) &&
                     (({1'b0, bullet_y_q} + 11'd10) >= 11'(100 + 50*i)) &&
                     ({1'b0, bullet_y_q} <= 11'(110 + 50*i));
    end
  end

  always_comb begin
    state_d         = state_q;
    ship_x_d        = ship_x_q;
    bullet_active_d = bullet_active_q;
    bullet_x_d      = bullet_x_q;
    bullet_y_d      = bullet_y_q;
    tgt_x_d         = tgt_x_q;
    tgt_dir_d       = tgt_dir_q;
    tgt_hit_d       = tgt_hit_q;
    score_d         = score_q;
    ammo_d          = ammo_q;
    level_d         = level_q;
    hit_found       = 1'b0;

    if (tick) begin
      // Default bullet flight; a hit in PLAY overrides this below.
      if (bullet_active_q) begin
        if (bullet_y_q <= 10'd10) bullet_active_d = 1'b0;
        else                      bullet_y_d      = bullet_y_q - 10'd10;
      end

      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_d   = S_PLAY;
            tgt_x_d   = RELOAD_X;
            tgt_dir_d = RELOAD_DIR;
            tgt_hit_d = '0;
            score_d   = 8'd0;
            level_d   = 4'd0;
            ammo_d    = AMMO_FULL;
            ship_x_d  = SHIP_HOME;
          end
        end

        S_PLAY: begin
          // Transitions look at the registered state, so a clear or the last
          // miss is acted on one tick later.
          if (all_hit)                                    state_d = S_LVL_CLR;
          else if ((ammo_q == 4'd0) && !bullet_active_q)  state_d = S_OVER;

          if (btn_right && !btn_left && (ship_x_q < 10'd610))
            ship_x_d = ship_x_q + 10'd5;
          else if (btn_left && !btn_right && (ship_x_q > 10'd30))
            ship_x_d = ship_x_q - 10'd5;

          // Lowest-index unhit target in the window takes the hit.
          for (int i = 0; i < NUM_TARGETS; i++) begin
            if (!hit_found && bullet_active_q && !tgt_hit_q[i] && in_window[i]) begin
              hit_found    = 1'b1;
              tgt_hit_d[i] = 1'b1;
            end
          end

          if (hit_found) begin
            bullet_active_d = 1'b0;
            bullet_y_d      = bullet_y_q;
            if (score_q != 8'hFF) score_d = score_q + 8'd1;
          end else if (fire_ok) begin
            bullet_active_d = 1'b1;
            bullet_x_d      = ship_x_q;
            bullet_y_d      = 10'd430;
            ammo_d          = ammo_q - 4'd1;
          end

          // A target hit on this tick freezes at its pre-update position.
          for (int i = 0; i < NUM_TARGETS; i++) begin
            if (!tgt_hit_d[i]) begin
              if (tgt_x_q[10*i +: 10] >= 10'd612)     tgt_dir_d[i] = 1'b1;
              else if (tgt_x_q[10*i +: 10] <= 10'd10) tgt_dir_d[i] = 1'b0;
              if (tgt_dir_d[i]) tgt_x_d[10*i +: 10] = tgt_x_q[10*i +: 10] - step_w;
              else              tgt_x_d[10*i +: 10] = tgt_x_q[10*i +: 10] + step_w;
            end
          end
        end

        S_LVL_CLR: begin
          state_d   = S_PLAY;
          tgt_x_d   = RELOAD_X;
          tgt_dir_d = RELOAD_DIR;
          tgt_hit_d = '0;
          ammo_d    = AMMO_FULL;
          if (level_q != 4'hF) level_d = level_q + 4'd1;
        end

        S_OVER: begin
          if (!start) state_d = S_IDLE;
        end

        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= S_IDLE;
      ship_x_q        <= SHIP_HOME;
      bullet_active_q <= 1'b0;
      bullet_x_q      <= 10'd0;
      bullet_y_q      <= 10'd0;
      tgt_x_q         <= RELOAD_X;
      tgt_dir_q       <= RELOAD_DIR;
      tgt_hit_q       <= '0;
      score_q         <= 8'd0;
      ammo_q          <= AMMO_FULL;
      level_q         <= 4'd0;
    end else begin
      state_q         <= state_d;
      ship_x_q        <= ship_x_d;
      bullet_active_q <= bullet_active_d;
      bullet_x_q      <= bullet_x_d;
      bullet_y_q      <= bullet_y_d;
      tgt_x_q         <= tgt_x_d;
      tgt_dir_q       <= tgt_dir_d;
      tgt_hit_q       <= tgt_hit_d;
      score_q         <= score_d;
      ammo_q          <= ammo_d;
      level_q         <= level_d;
    end
  end

  assign ship_x        = ship_x_q;
  assign bullet_active = bullet_active_q;
  assign bullet_x      = bullet_x_q;
  assign bullet_y      = bullet_y_q;
  assign tgt_x         = tgt_x_q;
  assign tgt_hit       = tgt_hit_q;
  assign score         = score_q;
  assign ammo          = ammo_q;
  assign level         = level_q;
  assign state         = state_q;

endmodule
`default_nettype wire

// File: tb/tb_astro_game_engine.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_astro_game_engine                                       |
// | Description : Self-checking bench. Two engines (4 targets and 1 target)  |
// |               share one stimulus stream; a game-rule model tracks both   |
// |               and every output is compared on each falling clock edge.   |
// |               Directed scenarios add hand-computed literal expectations. |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_astro_game_engine;

  localparam int AMMO_INIT = 8;
  localparam int TGT_STEP  = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic tick_i = 1'b0, start_i = 1'b0, left_i = 1'b0, right_i = 1'b0, fire_i = 1'b0;

  logic [9:0]  d4_ship, d4_bx, d4_by, d1_ship, d1_bx, d1_by;
  logic        d4_bact, d1_bact;
  logic [39:0] d4_tx;
  logic [9:0]  d1_tx;
  logic [3:0]  d4_hit;
  logic [0:0]  d1_hit;
  logic [7:0]  d4_score, d1_score;
  logic [3:0]  d4_ammo, d1_ammo, d4_level, d1_level;
  logic [1:0]  d4_state, d1_state;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  astro_game_engine #(.NUM_TARGETS(4), .AMMO_INIT(AMMO_INIT), .TGT_STEP(TGT_STEP)) u_dut4 (
    .clk(clk), .reset(reset), .tick(tick_i), .start(start_i),
    .btn_left(left_i), .btn_right(right_i), .btn_fire(fire_i),
    .ship_x(d4_ship), .bullet_active(d4_bact), .bullet_x(d4_bx), .bullet_y(d4_by),
    .tgt_x(d4_tx), .tgt_hit(d4_hit), .score(d4_score), .ammo(d4_ammo),
    .level(d4_level), .state(d4_state)
  );

  astro_game_engine #(.NUM_TARGETS(1), .AMMO_INIT(AMMO_INIT), .TGT_STEP(TGT_STEP)) u_dut1 (
    .clk(clk), .reset(reset), .tick(tick_i), .start(start_i),
    .btn_left(left_i), .btn_right(right_i), .btn_fire(fire_i),
    .ship_x(d1_ship), .bullet_active(d1_bact), .bullet_x(d1_bx), .bullet_y(d1_by),
    .tgt_x(d1_tx), .tgt_hit(d1_hit), .score(d1_score), .ammo(d1_ammo),
    .level(d1_level), .state(d1_state)
  );

  // ---------------- game-rule model (index 0: 4 targets, 1: 1 target) -----
  int nt[2] = '{4, 1};
  int m_state[2], m_ship[2], m_bact[2], m_bx[2], m_by[2];
  int m_score[2], m_ammo[2], m_level[2];
  int m_tx[2][8], m_dir[2][8], m_hit[2][8];

  task automatic model_reload(input int d);
    for (int i = 0; i < nt[d]; i++) begin
      m_tx[d][i]  = (20 + 150*i) % 600;
      m_dir[d][i] = (i % 2 == 0) ? 1 : -1;
      m_hit[d][i] = 0;
    end
  endtask

  task automatic model_reset(input int d);
    m_state[d] = 0; m_ship[d] = 400; m_bact[d] = 0; m_bx[d] = 0; m_by[d] = 0;
    m_score[d] = 0; m_ammo[d] = AMMO_INIT; m_level[d] = 0;
    model_reload(d);
  endtask

  task automatic model_step(input int d);
    int pb_act, pbx, pby, pship, hit_i, stp, allh, ty;
    if (!tick_i) return;
    pb_act = m_bact[d]; pbx = m_bx[d]; pby = m_by[d]; pship = m_ship[d];
    allh = 1;
    for (int i = 0; i < nt[d]; i++) if (m_hit[d][i] == 0) allh = 0;
    if (pb_act != 0) begin
      if (pby <= 10) m_bact[d] = 0;
      else           m_by[d]   = pby - 10;
    end
    case (m_state[d])
      0: if (start_i) begin
        m_state[d] = 1; model_reload(d);
        m_score[d] = 0; m_level[d] = 0; m_ammo[d] = AMMO_INIT; m_ship[d] = 400;
      end
      1: begin
        if (allh != 0) m_state[d] = 2;
        else if (m_ammo[d] == 0 && pb_act == 0) m_state[d] = 3;
        if (right_i && !left_i && pship < 610)      m_ship[d] = pship + 5;
        else if (left_i && !right_i && pship > 30)  m_ship[d] = pship - 5;
        hit_i = -1;
        if (pb_act != 0) begin
          for (int i = 0; i < nt[d]; i++) begin
            ty = 100 + 50*i;
            if (hit_i < 0 && m_hit[d][i] == 0 && pbx + 10 >= m_tx[d][i] && pbx <= m_tx[d][i] + 10
                && pby + 10 >= ty && pby <= ty + 10) hit_i = i;
          end
        end
        if (hit_i >= 0) begin
          m_hit[d][hit_i] = 1; m_bact[d] = 0; m_by[d] = pby;
          if (m_score[d] < 255) m_score[d]++;
        end else if (fire_i && !left_i && !right_i && pb_act == 0 && m_ammo[d] > 0) begin
          m_bact[d] = 1; m_bx[d] = pship; m_by[d] = 430; m_ammo[d]--;
        end
        stp = TGT_STEP;
`ifdef LEVEL_SPEEDUP_EN
        stp = TGT_STEP << ((m_level[d] < 2) ? m_level[d] : 2);
`endif
        for (int i = 0; i < nt[d]; i++) begin
          if (m_hit[d][i] == 0) begin
            if (m_tx[d][i] >= 612)     m_dir[d][i] = -1;
            else if (m_tx[d][i] <= 10) m_dir[d][i] = 1;
            m_tx[d][i] = m_tx[d][i] + m_dir[d][i] * stp;
          end
        end
      end
      2: begin
        model_reload(d); m_ammo[d] = AMMO_INIT; m_state[d] = 1;
        if (m_level[d] < 15) m_level[d]++;
      end
      default: if (!start_i) m_state[d] = 0;
    endcase
  endtask

  // ---------------- checking ------------------------------------------------
  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cmp(input int d, input logic [1:0] st, input logic [9:0] sx, input logic ba,
                     input logic [9:0] bx, input logic [9:0] by, input logic [7:0] sc,
                     input logic [3:0] am, input logic [3:0] lv, input logic [79:0] tx,
                     input logic [7:0] ht);
    string p;
    p = (d == 0) ? "d4" : "d1";
    chk({p, ".state"}, int'(st), m_state[d]);
    chk({p, ".ship_x"}, int'(sx), m_ship[d]);
    chk({p, ".bullet_active"}, int'(ba), m_bact[d]);
    chk({p, ".bullet_x"}, int'(bx), m_bx[d]);
    chk({p, ".bullet_y"}, int'(by), m_by[d]);
    chk({p, ".score"}, int'(sc), m_score[d]);
    chk({p, ".ammo"}, int'(am), m_ammo[d]);
    chk({p, ".level"}, int'(lv), m_level[d]);
    for (int i = 0; i < nt[d]; i++) begin
      chk($sformatf("%s.tgt_x[%0d]", p, i), int'(tx[10*i +: 10]), m_tx[d][i]);
      chk($sformatf("%s.tgt_hit[%0d]", p, i), int'(ht[i]), m_hit[d][i]);
    end
  endtask

  always @(negedge clk) begin
    cmp(0, d4_state, d4_ship, d4_bact, d4_bx, d4_by, d4_score, d4_ammo, d4_level,
        {40'd0, d4_tx}, {4'd0, d4_hit});
    cmp(1, d1_state, d1_ship, d1_bact, d1_bx, d1_by, d1_score, d1_ammo, d1_level,
        {70'd0, d1_tx}, {7'd0, d1_hit});
  end

  // ---------------- stimulus helpers ---------------------------------------
  task automatic step(input logic t, input logic s, input logic l, input logic r, input logic f);
    @(negedge clk);
    #1;
    tick_i = t; start_i = s; left_i = l; right_i = r; fire_i = f;
    @(posedge clk);
    model_step(0);
    model_step(1);
    #2;
    tick_i = 1'b0;
  endtask

  task automatic assert_reset();
    @(posedge clk);
    #2;
    reset = 1'b1;
    model_reset(0);
    model_reset(1);
    #1;
  endtask

  task automatic release_reset();
    @(posedge clk);
    #2;
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int step_l1;
`ifdef LEVEL_SPEEDUP_EN
    step_l1 = 4;
`else
    step_l1 = 2;
`endif
    model_reset(0);
    model_reset(1);
    repeat (2) @(posedge clk);
    #2;
    reset = 1'b0;

    // Reset state
    chk("rst.state", int'(d4_state), 0);
    chk("rst.ship_x", int'(d4_ship), 400);
    chk("rst.ammo", int'(d4_ammo), 8);
    chk("rst.tgt_x1", int'(d4_tx[19:10]), 170);
    chk("rst.tgt_x3", int'(d4_tx[39:30]), 470);

    // start without tick does nothing; with tick enters PLAY
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("notick.state", int'(d4_state), 0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("start.state", int'(d4_state), 1);
    chk("start.ship_x", int'(d4_ship), 400);
    chk("start.ammo", int'(d4_ammo), 8);
    chk("start.tgt_x0", int'(d4_tx[9:0]), 20);
    chk("start.tgt_x1", int'(d4_tx[19:10]), 170);

    // Ship right to the limit, tick gating, both buttons, then left
    for (int k = 1; k <= 42; k++) begin
      step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
      if (k == 41) chk("right41.ship_x", int'(d4_ship), 605);
    end
    chk("right42.ship_x", int'(d4_ship), 610);
    repeat (8) step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("right50.ship_x", int'(d4_ship), 610);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("notick_left.ship_x", int'(d4_ship), 610);
    repeat (3) step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("both.ship_x", int'(d4_ship), 610);
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("left.ship_x", int'(d4_ship), 605);

    // Mid-operation reset
    assert_reset();
    chk("midrst.state", int'(d4_state), 0);
    chk("midrst.ship_x", int'(d4_ship), 400);
    chk("midrst.tgt_x0", int'(d1_tx), 20);
    release_reset();

    // Fire, ignored refire, unopposed flight
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("fire.active", int'(d4_bact), 1);
    chk("fire.bullet_x", int'(d4_bx), 400);
    chk("fire.bullet_y", int'(d4_by), 430);
    chk("fire.ammo", int'(d4_ammo), 7);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("refire.ammo", int'(d4_ammo), 7);
    chk("refire.bullet_y", int'(d4_by), 420);
    repeat (41) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("flight42.bullet_y", int'(d4_by), 10);
    chk("flight42.active", int'(d4_bact), 1);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("flight43.active", int'(d4_bact), 0);

    // Timed shot into the single target, then level clear
    assert_reset();
    release_reset();
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    repeat (157) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    repeat (32) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("park.tgt_x0", int'(d1_tx), 400);
    chk("park.bullet_y", int'(d1_by), 110);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("hit.tgt_hit", int'(d1_hit), 1);
    chk("hit.score", int'(d1_score), 1);
    chk("hit.active", int'(d1_bact), 0);
    chk("hit.tgt_x0", int'(d1_tx), 400);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("clr.state", int'(d1_state), 2);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("lvl.state", int'(d1_state), 1);
    chk("lvl.level", int'(d1_level), 1);
    chk("lvl.ammo", int'(d1_ammo), 8);
    chk("lvl.tgt_hit", int'(d1_hit), 0);
    chk("lvl.tgt_x0", int'(d1_tx), 20);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("lvl.step", int'(d1_tx), 20 + step_l1);

    // Eight misses with fire and start held; bounce at 612; game over
    assert_reset();
    release_reset();
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int t = 1; t <= 355; t++) begin
      step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
      if (t == 296) chk("bounce.tgt_x0", int'(d1_tx), 612);
      if (t == 297) chk("bounce_next.tgt_x0", int'(d1_tx), 610);
      if (t == 352) begin
        chk("last_clear.state", int'(d1_state), 1);
        chk("last_clear.active", int'(d1_bact), 0);
        chk("last_clear.ammo", int'(d1_ammo), 0);
      end
      if (t == 353) chk("over.state", int'(d1_state), 3);
    end
    chk("over_hold.state", int'(d1_state), 3);
    chk("over_hold.score", int'(d1_score), 0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("idle.state", int'(d1_state), 0);
    chk("idle.level", int'(d1_level), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/astro_game_engine.md
ASTRO_GAME_ENGINE -- requirements
Module: astro_game_engine

Interface
REQ-001 SHALL have parameter NUM_TARGETS, default 4: number of targets (1..8); target i moves in lane Y = 100 + 50*i.
REQ-002 SHALL have parameter AMMO_INIT, default 8: shots per level (1..15).
REQ-003 SHALL have parameter TGT_STEP, default 2: base target X step per tick.
REQ-004 SHALL have the port: clk  in  1  system clock; the single clock.
REQ-005 SHALL have the port: reset  in  1  asynchronous, active-high reset.
REQ-006 SHALL have the port: tick  in  1  one-cycle game-update enable (frame rate); no state changes when low.
REQ-007 SHALL have the ports: start, btn_left, btn_right, btn_fire  in  1 each  debounced level inputs.
REQ-008 SHALL have the port: ship_x  out  10  ship centre X.
REQ-009 SHALL have the ports: bullet_active out 1, bullet_x out 10, bullet_y out 10  bullet state and position.
REQ-010 SHALL have the port: tgt_x  out  10*NUM_TARGETS  packed target X; target i occupies bits [10i+9:10i].
REQ-011 SHALL have the port: tgt_hit  out  NUM_TARGETS  per-target hit flags.
REQ-012 SHALL have the ports: score out 8, ammo out 4, level out 4, state out 2.

Function
REQ-013 SHALL evaluate all updates only on clk edges where tick=1.
REQ-014 SHALL implement FSM states IDLE=00, PLAY=01, LVL_CLR=10, OVER=11.
REQ-015 SHALL transition IDLE->PLAY when start=1.
REQ-016 SHALL transition PLAY->LVL_CLR when all tgt_hit bits are set.
REQ-017 SHALL, on the LVL_CLR tick, reload targets (REQ-024), set ammo=AMMO_INIT, increment level (saturating at 15), and move to PLAY.
REQ-018 SHALL transition PLAY->OVER when ammo=0, bullet_active=0, and not all targets are hit.
REQ-019 SHALL transition OVER->IDLE when start=0; score and level SHALL hold until the next reload.
REQ-020 SHALL, in PLAY only, move the ship: btn_right&~btn_left with ship_x<610 -> +5; btn_left&~btn_right with ship_x>30 -> -5; otherwise hold.
REQ-021 SHALL fire in PLAY on btn_fire&~btn_left&~btn_right&~bullet_active&(ammo>0): bullet_active=1, bullet_x=ship_x, bullet_y=430, ammo-1; fire requests while a bullet is active SHALL be ignored.
REQ-022 SHALL move an active bullet each tick: bullet_y<=10 -> bullet_active=0; else bullet_y-10.
REQ-023 SHALL register a hit on an unhit target i when bullet_x+10>=tx, bullet_x<=tx+10, bullet_y+10>=ty, and bullet_y<=ty+10, evaluated on pre-update values without underflow; only the lowest-index target is hit; set tgt_hit[i], clear bullet_active, score+1 (saturating at 255); the hit takes precedence over the bullet moving.
REQ-024 SHALL move unhit targets in PLAY: x>=612 -> direction=left; x<=10 -> direction=right; the step uses the newly selected direction; hit targets freeze.
REQ-025 SHALL reload targets on IDLE->PLAY and in LVL_CLR: tgt_x = 20+150*i mod 600, even i moving right, odd i moving left, tgt_hit=0.
REQ-026 SHALL also clear score, set level=0, set ammo=AMMO_INIT, and set ship_x=400 on IDLE->PLAY.

Reset
REQ-027 SHALL, on asserted reset, immediately (mid-operation included) drive: state=IDLE, ship_x=400, bullet_active=0, bullet_x=0, bullet_y=0, tgt_x per REQ-025, tgt_hit=0, score=0, ammo=AMMO_INIT, level=0, all directions per REQ-025.
REQ-028 SHALL make the first tick after reset release be evaluated normally.

Configuration
REQ-029 SHALL, with LEVEL_SPEEDUP_EN defined, use target step TGT_STEP<<min(level,2) (2, 4, 8 at default).
REQ-030 SHALL, without LEVEL_SPEEDUP_EN, use a constant target step of TGT_STEP; level still counts.

Verification
REQ-031 SHALL cover: reset, start=1 with one tick -> state=01, ship_x=400, ammo=8, tgt_x[0]=20, tgt_x[1]=170.
REQ-032 SHALL cover: btn_right held 50 ticks from 400 -> ship_x 610 after 42 ticks, then holds; btn_left+btn_right together -> no move.
REQ-033 SHALL cover: fire at ship_x=400 -> bullet (400,430), ammo 7; second fire while active ignored; unopposed bullet clears after 43 ticks.
REQ-034 SHALL cover: target parked in bullet path (NUM_TARGETS=1, tgt at x=400) -> tgt_hit=1, score=1, bullet cleared same tick, then LVL_CLR -> level=1, ammo reloaded.
REQ-035 SHALL cover: 8 misses -> state=11 on the tick after the last bullet clears; start=0 -> state=00.
REQ-036 SHALL cover: target bounce: x reaches 612 -> next x=610; with LEVEL_SPEEDUP_EN at level 2, step 8 observed.
